ts_packet_framer: RTL and testbench
===================================

Name: ts_packet_framer

Overview:
MPEG-2 TS transmit framer, the send-side counterpart of the sync recovery receiver. It builds 188-byte transport packets from a raw payload byte stream. Each packet gets a 4-byte header: sync 0x47, PID, PUSI and continuity counter. When no payload is ready, the block optionally emits null packets so the output byte rate stays constant. It sits between the payload source and the TS output/mux, one byte per enabled cycle.

Parameters:
PID, 13'h0100, PID placed in data packet headers.
NULL_INSERT, 1, 1 = emit null packets when no payload is ready; 0 = idle (byte_valid low).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
out_en  in  1  downstream byte slot; one output byte is produced per cycle with out_en=1
pkt_avail  in  1  source holds at least 184 payload bytes; sampled only at packet start
pusi  in  1  payload_unit_start flag for the next data packet; sampled at packet start
in_byte  in  8  payload byte
in_valid  in  1  payload byte valid
in_ready  out  1  payload byte consumed this edge; combinational = out_en & (state==PAYLOAD) & is_data
byte_out  out  8  TS byte, registered
byte_valid  out  1  byte_out valid this cycle, registered
pkt_start  out  1  high with byte 0 (0x47) of every packet
cc_out  out  4  continuity counter of the current or last data packet
underrun_err  out  1  sticky; set when in_valid is low while a payload byte is needed

Behaviour:
- Reset (async, rst=0): byte_out=0, byte_valid=0, pkt_start=0, cc=0, underrun_err=0, state=START, idx=0, is_data=0. Takes effect immediately, including mid-packet. The partial packet is abandoned and not completed.
- Registered output; latency is one clk. On an edge with out_en=1, the byte for the current idx loads into byte_out and byte_valid<=1. On an edge with out_en=0, byte_valid<=0, byte_out holds and no state advances.
- idx counts 0..187 and wraps to 0 after 187. States: START (idx=0), HDR (idx 1..3), PAYLOAD (idx 4..187).
- START, out_en=1:
  - pkt_avail=1: is_data<=1, latch pusi, emit 0x47, pkt_start<=1, go HDR.
  - pkt_avail=0, NULL_INSERT=1: is_data<=0, emit 0x47, pkt_start<=1, go HDR.
  - pkt_avail=0, NULL_INSERT=0: byte_valid<=0, stay in START.
- pkt_start is 0 on every other cycle.
- Header, data packet: B1 = {TEI=0, PUSI_latched, prio=0, PID[12:8]}; B2 = PID[7:0]; B3 = {scr=2'b00, afc=2'b01, cc}.
- Header, null packet: B1 = 0x1F, B2 = 0xFF, B3 = 0x10 (cc field 0).
- cc increments (mod 16, wraps F->0) on the edge that emits B3 of a data packet. The emitted B3 carries the pre-increment value; cc_out shows that value until the next data B3. Null packets never change cc.
- PAYLOAD, data packet:
  - in_valid=1: byte_out<=in_byte, consumed via in_ready.
  - in_valid=0: byte_out<=0xFF, underrun_err<=1 (sticky until reset). Packet length stays 188.
- PAYLOAD, null packet: byte_out<=0xFF, in_ready=0.
- After idx 187 go START. With continuous out_en and data, packets are back-to-back with no gap.
- pkt_avail and pusi changes mid-packet are ignored. in_ready is never high outside PAYLOAD of a data packet.

Test Plan:
- PID=0x100, pkt_avail=1, pusi=1, payload 0x00..0xB7, out_en=1 -> bytes 47 41 00 10 00 01 .. B7 (188 total), pkt_start only on the 47, exactly 184 in_ready pulses.
- 17 back-to-back data packets -> B3 values 10,11,..,1F,10; cc wraps F->0; no idle byte between packets.
- NULL_INSERT=1, pkt_avail=0 for one packet between two data packets -> data (cc=0), null 47 1F FF 10 + 184x FF, data (cc=1); null packet leaves cc unchanged.
- out_en toggling 1,0,1,0 through one packet -> byte_valid only on the cycles after out_en=1, byte_out held during gaps, 188 valid bytes, in_ready=0 while out_en=0.
- in_valid low at payload index 100 -> that byte 0xFF, underrun_err=1 and stays set, packet still 188 bytes; NULL_INSERT=0 with pkt_avail=0 -> byte_valid stays 0.
- rst asserted at idx 50 -> all outputs 0 immediately; after release with pkt_avail=1, first byte 47 with pkt_start=1 and B3=0x10.

Source files
------------

// File: rtl/ts_packet_framer_if.sv
// Byte-stream bundle between the payload source / TS sink and the packet framer.
// Handshake: a payload byte transfers on a clk edge where in_ready=1 and in_valid=1;
// an output byte is valid in the cycle after an edge with out_en=1 (byte_valid=1).
interface ts_packet_framer_if;
    logic       out_en;
    logic       pkt_avail;
    logic       pusi;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       pkt_start;
    logic [3:0] cc_out;
    logic       underrun_err;
    logic [1:0] state_dbg;

    modport master (
        output out_en, pkt_avail, pusi, in_byte, in_valid,
        input  in_ready, byte_out, byte_valid, pkt_start, cc_out, underrun_err, state_dbg
    );

    modport slave (
        input  out_en, pkt_avail, pusi, in_byte, in_valid,
        output in_ready, byte_out, byte_valid, pkt_start, cc_out, underrun_err, state_dbg
    );
endinterface

// File: rtl/ts_packet_framer.sv
// MPEG-2 TS transmit framer: wraps a payload byte stream into 188-byte packets
// with a 4-byte header, optionally filling idle slots with null packets.
module ts_packet_framer #(
    parameter logic [12:0] PID         = 13'h0100,
    parameter bit          NULL_INSERT = 1'b1
) (
    input logic             clk,
    input logic             rst,
    ts_packet_framer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_START   = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic       is_data_q, is_data_d;
    logic       pusi_q, pusi_d;
    logic [3:0] cc_q, cc_d;
    logic [3:0] cc_out_q, cc_out_d;
    logic [7:0] byte_out_q, byte_out_d;
    logic       byte_valid_q, byte_valid_d;
    logic       pkt_start_q, pkt_start_d;
    logic       underrun_q, underrun_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_START;
            idx_q        <= 8'd0;
            is_data_q    <= 1'b0;
            pusi_q       <= 1'b0;
            cc_q         <= 4'd0;
            cc_out_q     <= 4'd0;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            pkt_start_q  <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            is_data_q    <= is_data_d;
            pusi_q       <= pusi_d;
            cc_q         <= cc_d;
            cc_out_q     <= cc_out_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            pkt_start_q  <= pkt_start_d;
            underrun_q   <= underrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        is_data_d    = is_data_q;
        pusi_d       = pusi_q;
        cc_d         = cc_q;
        cc_out_d     = cc_out_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        pkt_start_d  = 1'b0;
        underrun_d   = underrun_q;
        if (bus.out_en) begin
            unique case (state_q)
                ST_START: begin
                    // Without payload and without null insertion the slot stays idle.
                    if (bus.pkt_avail || NULL_INSERT) begin
                        is_data_d    = bus.pkt_avail;
                        pusi_d       = bus.pkt_avail & bus.pusi;
                        byte_out_d   = 8'h47;
                        byte_valid_d = 1'b1;
                        pkt_start_d  = 1'b1;
                        idx_d        = 8'd1;
                        state_d      = ST_HDR;
                    end
                end
                ST_HDR: begin
                    byte_valid_d = 1'b1;
                    idx_d        = idx_q + 8'd1;
                    case (idx_q[1:0])
                        2'd1:    byte_out_d = is_data_q ? {1'b0, pusi_q, 1'b0, PID[12:8]} : 8'h1F;
                        2'd2:    byte_out_d = is_data_q ? PID[7:0] : 8'hFF;
                        default: begin
                            state_d = ST_PAYLOAD;
                            if (is_data_q) begin
                                byte_out_d = {4'b0001, cc_q};
                                cc_out_d   = cc_q;
                                cc_d       = cc_q + 4'd1;
                            end else begin
                                byte_out_d = 8'h10;
                            end
                        end
                    endcase
                end
                ST_PAYLOAD: begin
                    byte_valid_d = 1'b1;
                    if (!is_data_q) begin
                        byte_out_d = 8'hFF;
                    end else if (bus.in_valid) begin
                        byte_out_d = bus.in_byte;
                    end else begin
                        // Stuff 0xFF so the packet keeps its full length.
                        byte_out_d = 8'hFF;
                        underrun_d = 1'b1;
                    end
                    if (idx_q == 8'd187) begin
                        idx_d   = 8'd0;
                        state_d = ST_START;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
                default: begin
                    idx_d   = 8'd0;
                    state_d = ST_START;
                end
            endcase
        end
    end

    assign bus.in_ready     = bus.out_en & (state_q == ST_PAYLOAD) & is_data_q;
    assign bus.byte_out     = byte_out_q;
    assign bus.byte_valid   = byte_valid_q;
    assign bus.pkt_start    = pkt_start_q;
    assign bus.cc_out       = cc_out_q;
    assign bus.underrun_err = underrun_q;
    assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_ts_packet_framer.sv
// Directed bench for ts_packet_framer: header/payload contents, cc wrap, null
// packets, out_en gaps, payload underrun, idle mode and asynchronous reset.
module tb_ts_packet_framer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ts_packet_framer_if bus ();
    ts_packet_framer_if bus2 ();

    ts_packet_framer #(.PID(13'h0100), .NULL_INSERT(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    ts_packet_framer #(.PID(13'h0100), .NULL_INSERT(1'b0)) dut_idle (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] last_byte;
    logic [7:0] exp_q[$];

    // Drives one packet (or its first stop_at bytes) and checks every cycle.
    task automatic send_packet(input bit avail, input bit p, input logic [3:0] exp_cc,
                               input bit toggle, input int bad_idx, input int stop_at);
        int pos = 0;
        int cyc = 0;
        int rdy_cnt = 0;
        bit en;
        bit exp_rdy;
        logic [7:0] exp_b;
        exp_q.delete();
        exp_q.push_back(8'h47);
        if (avail) begin
            exp_q.push_back({1'b0, p, 1'b0, 5'h01});
            exp_q.push_back(8'h00);
            exp_q.push_back({4'h1, exp_cc});
        end else begin
            exp_q.push_back(8'h1F);
            exp_q.push_back(8'hFF);
            exp_q.push_back(8'h10);
        end
        for (int k = 0; k < 184; k++)
            exp_q.push_back((avail && k != bad_idx) ? 8'(k) : 8'hFF);
        while (pos < 188 && pos < stop_at && cyc < 2000) begin
            en = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.out_en    = en;
            bus.pkt_avail = (pos == 0) ? avail : ~avail;
            bus.pusi      = (pos == 0) ? p : ~p;
            bus.in_valid  = !(pos >= 4 && (pos - 4) == bad_idx);
            bus.in_byte   = (pos >= 4 && bus.in_valid) ? 8'(pos - 4) : 8'h5A;
            #1;
            exp_rdy = en && avail && pos >= 4;
            checks++;
            if (bus.in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL in_ready pos=%0d got=%b exp=%b", pos, bus.in_ready, exp_rdy);
            end
            if (bus.in_ready === 1'b1) rdy_cnt++;
            @(posedge clk);
            #1;
            if (en) begin
                exp_b = exp_q.pop_front();
                checks += 3;
                if (bus.byte_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL byte_valid pos=%0d got=%b exp=1", pos, bus.byte_valid);
                end
                if (bus.byte_out !== exp_b) begin
                    errors++;
                    $display("FAIL byte_out pos=%0d got=%h exp=%h", pos, bus.byte_out, exp_b);
                end
                if (bus.pkt_start !== (pos == 0)) begin
                    errors++;
                    $display("FAIL pkt_start pos=%0d got=%b exp=%b", pos, bus.pkt_start, pos == 0);
                end
                last_byte = exp_b;
                pos++;
            end else begin
                checks += 3;
                if (bus.byte_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_valid pos=%0d got=%b exp=0", pos, bus.byte_valid);
                end
                if (bus.byte_out !== last_byte) begin
                    errors++;
                    $display("FAIL gap_hold pos=%0d got=%h exp=%h", pos, bus.byte_out, last_byte);
                end
                if (bus.pkt_start !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_pkt_start pos=%0d got=%b exp=0", pos, bus.pkt_start);
                end
            end
            cyc++;
        end
        if (stop_at >= 188) begin
            checks += 3;
            if (pos != 188) begin
                errors++;
                $display("FAIL pkt_len got=%0d exp=188", pos);
            end
            if (rdy_cnt != (avail ? 184 : 0)) begin
                errors++;
                $display("FAIL ready_count got=%0d exp=%0d", rdy_cnt, avail ? 184 : 0);
            end
            if (bus.cc_out !== exp_cc) begin
                errors++;
                $display("FAIL cc_out got=%h exp=%h", bus.cc_out, exp_cc);
            end
        end
    endtask

    task automatic check_underrun(input bit exp);
        checks++;
        if (bus.underrun_err !== exp) begin
            errors++;
            $display("FAIL underrun_err got=%b exp=%b", bus.underrun_err, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        checks++;
        if (bus.byte_out !== 8'h00 || bus.byte_valid !== 1'b0 || bus.pkt_start !== 1'b0 ||
            bus.cc_out !== 4'h0 || bus.underrun_err !== 1'b0 || bus.in_ready !== 1'b0 ||
            bus.state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL %s got=%h/%b/%b/%h/%b/%b/%0d exp=00/0/0/0/0/0/0", tag, bus.byte_out,
                     bus.byte_valid, bus.pkt_start, bus.cc_out, bus.underrun_err,
                     bus.in_ready, bus.state_dbg);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.out_en = 1'b0; bus.pkt_avail = 1'b0; bus.pusi = 1'b0;
        bus.in_byte = 8'h00; bus.in_valid = 1'b0;
        bus2.out_en = 1'b0; bus2.pkt_avail = 1'b0; bus2.pusi = 1'b0;
        bus2.in_byte = 8'h00; bus2.in_valid = 1'b0;
        last_byte = 8'h00;
        #3;
        check_zero_outputs("reset_state");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_first_packet();
        send_packet(1'b1, 1'b1, 4'h0, 1'b0, -1, 188);
        check_underrun(1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 16; i++)
            send_packet(1'b1, i[0], 4'(i), 1'b0, -1, 188);
    endtask

    task automatic test_null_insert();
        send_packet(1'b1, 1'b0, 4'h1, 1'b0, -1, 188);
        send_packet(1'b0, 1'b0, 4'h1, 1'b0, -1, 188);
        send_packet(1'b1, 1'b1, 4'h2, 1'b0, -1, 188);
    endtask

    task automatic test_out_en_toggle();
        send_packet(1'b1, 1'b1, 4'h3, 1'b1, -1, 188);
    endtask

    task automatic test_underrun();
        send_packet(1'b1, 1'b0, 4'h4, 1'b0, 100, 188);
        check_underrun(1'b1);
        send_packet(1'b1, 1'b0, 4'h5, 1'b0, -1, 188);
        check_underrun(1'b1);
    endtask

    task automatic test_no_null();
        bus.out_en = 1'b0;
        bus2.out_en = 1'b1;
        bus2.pkt_avail = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus2.byte_valid !== 1'b0 || bus2.pkt_start !== 1'b0) begin
                errors++;
                $display("FAIL idle_valid cyc=%0d got=%b/%b exp=0/0", i, bus2.byte_valid,
                         bus2.pkt_start);
            end
        end
        bus2.pkt_avail = 1'b1;
        bus2.pusi = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus2.byte_out !== 8'h47 || bus2.byte_valid !== 1'b1 || bus2.pkt_start !== 1'b1) begin
            errors++;
            $display("FAIL idle_sync got=%h/%b/%b exp=47/1/1", bus2.byte_out, bus2.byte_valid,
                     bus2.pkt_start);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus2.byte_out !== 8'h01) begin
            errors++;
            $display("FAIL idle_b1 got=%h exp=01", bus2.byte_out);
        end
        bus2.out_en = 1'b0;
    endtask

    task automatic test_mid_reset();
        send_packet(1'b1, 1'b1, 4'h6, 1'b0, -1, 50);
        bus.out_en = 1'b1;
        bus.pkt_avail = 1'b1;
        bus.in_valid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        last_byte = 8'h00;
        @(posedge clk);
        #1 rst = 1'b1;
        send_packet(1'b1, 1'b1, 4'h0, 1'b0, -1, 188);
        check_underrun(1'b0);
    endtask

    initial begin
        test_reset();
        test_first_packet();
        test_back_to_back();
        test_null_insert();
        test_out_en_toggle();
        test_underrun();
        test_no_null();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
